// File: rtl/sim_monitor_pkg.sv
// Shared types and status codes for the run controller / bus monitor.
package sim_monitor_pkg;

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } run_state_t;

    localparam logic [2:0] STATUS_HOLD    = 3'd0;
    localparam logic [2:0] STATUS_RUN     = 3'd1;
    localparam logic [2:0] STATUS_PASS    = 3'd2;
    localparam logic [2:0] STATUS_FAIL    = 3'd3;
    localparam logic [2:0] STATUS_TIMEOUT = 3'd4;

    // Log record at the default 32-bit bus widths.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } log_entry_t;

endpackage

// File: rtl/write_log_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only if a pop frees a slot on the same edge.
module write_log_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/sim_run_monitor.sv
// Core reset sequencer, watchdog and data-memory write monitor with a readable write log.
module sim_run_monitor
    import sim_monitor_pkg::*;
#(
    parameter int                 DATA_W         = 32,
    parameter int                 ADDR_W         = 32,
    parameter int                 RESET_CYCLES   = 2,
    parameter int                 TIMEOUT_CYCLES = 1000,
    parameter logic [ADDR_W-1:0]  PASS_ADDR      = 32'h64,
    parameter logic [DATA_W-1:0]  PASS_DATA      = 32'd7,
    parameter int                 LOG_DEPTH      = 16,
    parameter int                 CNT_W          = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    output logic                         core_reset,
    input  logic                         mem_write,
    input  logic [ADDR_W-1:0]            data_adr,
    input  logic [DATA_W-1:0]            write_data,
    input  logic                         log_rd_en,
    output logic                         log_valid,
    output logic [ADDR_W-1:0]            log_addr,
    output logic [DATA_W-1:0]            log_data,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         log_overflow,
    output logic                         done,
    output logic                         pass,
    output logic [2:0]                   status,
    output logic [CNT_W-1:0]             cycle_count,
    output logic [CNT_W-1:0]             write_count
);
    localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    run_state_t         r_state;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_core_reset;
    logic               r_done;
    logic               r_pass;
    logic               r_overflow;
    logic [2:0]         r_status;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [CNT_W-1:0]   r_write_cnt;

    logic               w_run;
    logic               w_push;
    logic               w_hit_addr;
    logic               w_pass_wr;
    logic               w_fail_wr;
    logic               w_timeout;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_head;

    assign w_run      = (r_state == S_RUN);
    assign w_push     = w_run && mem_write;
    assign w_hit_addr = (data_adr == PASS_ADDR);
    assign w_pass_wr  = w_push && w_hit_addr && (write_data == PASS_DATA);
    assign w_fail_wr  = w_push && w_hit_addr && (write_data != PASS_DATA);
    assign w_timeout  = w_run && (r_cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    write_log_fifo #(
        .DEPTH (LOG_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_log (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_pop   (log_rd_en),
        .i_data  ({data_adr, write_data}),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (log_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_HOLD;
            r_hold_cnt   <= '0;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_overflow   <= 1'b0;
            r_status     <= STATUS_HOLD;
            r_cycle_cnt  <= '0;
            r_write_cnt  <= '0;
        end else begin
            // A full log only drops the write when no pop frees a slot that edge.
            if (w_push && w_full && !log_rd_en) r_overflow <= 1'b1;

            case (r_state)
                S_HOLD: begin
                    if (r_hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
                        r_state      <= S_RUN;
                        r_core_reset <= 1'b0;
                        r_status     <= STATUS_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                    if (w_push && (r_write_cnt != {CNT_W{1'b1}}))
                        r_write_cnt <= r_write_cnt + CNT_W'(1);

                    // Terminal write outranks the watchdog on the same edge.
                    if (w_pass_wr) begin
                        r_state      <= S_PASS;
                        r_status     <= STATUS_PASS;
                        r_pass       <= 1'b1;
                        r_done       <= 1'b1;
                        r_core_reset <= 1'b1;
                    end else if (w_fail_wr) begin
                        r_state      <= S_FAIL;
                        r_status     <= STATUS_FAIL;
                        r_done       <= 1'b1;
                        r_core_reset <= 1'b1;
                    end else if (w_timeout) begin
                        r_state      <= S_TIMEOUT;
                        r_status     <= STATUS_TIMEOUT;
                        r_done       <= 1'b1;
                        r_core_reset <= 1'b1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign core_reset   = r_core_reset;
    assign done         = r_done;
    assign pass         = r_pass;
    assign status       = r_status;
    assign cycle_count  = r_cycle_cnt;
    assign write_count  = r_write_cnt;
    assign log_overflow = r_overflow;
    assign log_valid    = !w_empty;
    assign log_addr     = w_head[ENTRY_W-1:DATA_W];
    assign log_data     = w_head[DATA_W-1:0];

endmodule

// File: tb/tb_sim_run_monitor.sv
// Bench for sim_run_monitor: hand tables for directed cases plus a queue-based reference model under random traffic.
module tb_sim_run_monitor;
    import sim_monitor_pkg::*;

    localparam int          TO    = 20;
    localparam int          DEPTH = 4;
    localparam int          RSTC  = 2;
    localparam logic [31:0] PADDR = 32'h64;
    localparam logic [31:0] PDATA = 32'd7;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        core_reset;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] write_data;
    logic        log_rd_en;
    logic        log_valid;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic [2:0]  log_count;
    logic        log_overflow;
    logic        done;
    logic        pass;
    logic [2:0]  status;
    logic [31:0] cycle_count;
    logic [31:0] write_count;

    sim_run_monitor #(
        .RESET_CYCLES   (RSTC),
        .TIMEOUT_CYCLES (TO),
        .LOG_DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .core_reset   (core_reset),
        .mem_write    (mem_write),
        .data_adr     (data_adr),
        .write_data   (write_data),
        .log_rd_en    (log_rd_en),
        .log_valid    (log_valid),
        .log_addr     (log_addr),
        .log_data     (log_data),
        .log_count    (log_count),
        .log_overflow (log_overflow),
        .done         (done),
        .pass         (pass),
        .status       (status),
        .cycle_count  (cycle_count),
        .write_count  (write_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: verdict code, edge counters and the log as a queue.
    int         m_st;
    int         m_hold;
    int         m_cycles;
    int         m_writes;
    bit         m_ovf;
    log_entry_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = 0; m_hold = 0; m_cycles = 0; m_writes = 0; m_ovf = 0;
        q.delete();
    endfunction

    function automatic void model_edge(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit rd);
        log_entry_t e;
        if (rd && q.size() > 0) void'(q.pop_front());
        if (m_st == 1 && wr) begin
            e.addr = a; e.data = d;
            if (q.size() < DEPTH) q.push_back(e);
            else m_ovf = 1;
        end
        if (m_st == 0) begin
            m_hold++;
            if (m_hold == RSTC) m_st = 1;
        end else if (m_st == 1) begin
            m_cycles++;
            if (wr) m_writes++;
            if (wr && a == PADDR) m_st = (d == PDATA) ? 2 : 3;
            else if (m_cycles == TO) m_st = 4;
        end
    endfunction

    task automatic check_model();
        chk("core_reset",   64'(core_reset),   64'(m_st != 1));
        chk("done",         64'(done),         64'(m_st >= 2));
        chk("pass",         64'(pass),         64'(m_st == 2));
        chk("status",       64'(status),       64'(m_st));
        chk("cycle_count",  64'(cycle_count),  64'(m_cycles));
        chk("write_count",  64'(write_count),  64'(m_writes));
        chk("log_count",    64'(log_count),    64'(q.size()));
        chk("log_valid",    64'(log_valid),    64'(q.size() != 0));
        chk("log_overflow", 64'(log_overflow), 64'(m_ovf));
        if (q.size() != 0) begin
            chk("log_addr", 64'(log_addr), 64'(q[0].addr));
            chk("log_data", 64'(log_data), 64'(q[0].data));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_edge(mem_write, data_adr, write_data, log_rd_en);
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        mem_write = 0; data_adr = '0; write_data = '0; log_rd_en = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit rd);
        mem_write = 1; data_adr = a; write_data = d; log_rd_en = rd;
        cycle();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        #1;
        model_reset();
        check_model();
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        chk("rst_status",     64'(status),     64'd0);
        repeat (3) cycle();
        reset_n = 1;
    endtask

    task automatic start_run();
        do_reset();
        cycle();
        chk("seq_core_reset_e1", 64'(core_reset), 64'd1);
        chk("seq_status_e1",     64'(status),     64'd0);
        cycle();
        chk("seq_core_reset_e2", 64'(core_reset), 64'd0);
        chk("seq_status_e2",     64'(status),     64'd1);
    endtask

    task automatic mid_reset();
        reset_n = 0;
        #1;
        model_reset();
        chk("mid_status",     64'(status),     64'd0);
        chk("mid_core_reset", 64'(core_reset), 64'd1);
        chk("mid_log_valid",  64'(log_valid),  64'd0);
        chk("mid_log_count",  64'(log_count),  64'd0);
        chk("mid_cycles",     64'(cycle_count), 64'd0);
        chk("mid_writes",     64'(write_count), 64'd0);
        check_model();
        idle_inputs();
        cycle();
        reset_n = 1;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        bit          rd;
        int          exp_status;
        int          exp_cnt;
        logic [31:0] exp_haddr;
        logic [31:0] exp_hdata;
    } vec_t;

    vec_t tbl[5];

    initial begin
        idle_inputs();
        reset_n = 1;
        #1;

        // Pass sequence and readback of the log after the verdict.
        tbl[0] = '{1, 32'h10, 32'd5, 0, 1, 1, 32'h10, 32'd5};
        tbl[1] = '{1, 32'h64, 32'd7, 0, 2, 2, 32'h10, 32'd5};
        tbl[2] = '{0, 32'h0,  32'd0, 1, 2, 1, 32'h64, 32'd7};
        tbl[3] = '{0, 32'h0,  32'd0, 1, 2, 0, 32'h0,  32'd0};
        tbl[4] = '{1, 32'h20, 32'd1, 0, 2, 0, 32'h0,  32'd0};

        start_run();
        for (int i = 0; i < 5; i++) begin
            mem_write = tbl[i].wr; data_adr = tbl[i].addr;
            write_data = tbl[i].data; log_rd_en = tbl[i].rd;
            cycle();
            idle_inputs();
            chk($sformatf("tbl%0d_status", i), 64'(status), 64'(tbl[i].exp_status));
            chk($sformatf("tbl%0d_count", i), 64'(log_count), 64'(tbl[i].exp_cnt));
            if (tbl[i].exp_cnt != 0) begin
                chk($sformatf("tbl%0d_haddr", i), 64'(log_addr), 64'(tbl[i].exp_haddr));
                chk($sformatf("tbl%0d_hdata", i), 64'(log_data), 64'(tbl[i].exp_hdata));
            end
        end
        chk("pass_done",        64'(done),        64'd1);
        chk("pass_pass",        64'(pass),        64'd1);
        chk("pass_write_count", 64'(write_count), 64'd2);
        chk("pass_core_reset",  64'(core_reset),  64'd1);

        // Fail is sticky against a later passing write.
        start_run();
        wr(32'h64, 32'd8, 0);
        chk("fail_status", 64'(status), 64'd3);
        chk("fail_pass",   64'(pass),   64'd0);
        chk("fail_done",   64'(done),   64'd1);
        wr(32'h64, 32'd7, 0);
        chk("fail_sticky", 64'(status), 64'd3);

        // Watchdog expiry, then a pass write on the expiry edge.
        start_run();
        repeat (TO - 1) cycle();
        chk("to_status_19", 64'(status), 64'd1);
        cycle();
        chk("to_status_20", 64'(status), 64'd4);
        chk("to_cycles",    64'(cycle_count), 64'd20);
        start_run();
        repeat (TO - 1) cycle();
        wr(32'h64, 32'd7, 0);
        chk("to_write_wins", 64'(status), 64'd2);

        // Overflow, then push+pop while full.
        start_run();
        for (int i = 0; i < 6; i++) wr(32'h100 + 32'(i), 32'(i + 1), 0);
        chk("ovf_count", 64'(log_count),    64'd4);
        chk("ovf_flag",  64'(log_overflow), 64'd1);
        chk("ovf_head0", 64'(log_addr),     64'h100);
        wr(32'h200, 32'hAA, 1);
        chk("ovf_pp_count", 64'(log_count), 64'd4);
        begin
            logic [31:0] exp_a [4];
            exp_a[0] = 32'h101; exp_a[1] = 32'h102; exp_a[2] = 32'h103; exp_a[3] = 32'h200;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("ovf_read%0d", i), 64'(log_addr), 64'(exp_a[i]));
                log_rd_en = 1;
                cycle();
                log_rd_en = 0;
            end
        end
        chk("ovf_empty", 64'(log_valid), 64'd0);

        // Mid-run reset with three entries logged.
        start_run();
        for (int i = 0; i < 3; i++) wr(32'h30 + 32'(i), 32'(i), 0);
        chk("mid_pre_count", 64'(log_count), 64'd3);
        mid_reset();

        // Random traffic against the model.
        for (int r = 0; r < 12; r++) begin
            start_run();
            for (int c = 0; c < 40; c++) begin
                mem_write = ($urandom_range(0, 9) < 4);
                if ($urandom_range(0, 9) == 0) begin
                    data_adr = PADDR;
                    write_data = ($urandom_range(0, 1) == 1) ? PDATA : 32'($urandom_range(0, 15));
                end else begin
                    data_adr = 32'($urandom_range(0, 255));
                    write_data = $urandom;
                end
                log_rd_en = ($urandom_range(0, 9) < 3);
                cycle();
                if ($urandom_range(0, 59) == 0) mid_reset();
            end
            idle_inputs();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
